rgb_pixel_streamer: RTL and testbench
=====================================

RGB_PIXEL_STREAMER -- requirements
Module: rgb_pixel_streamer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; ports are named Clock and Reset.
REQ-002 Parameter RGB_BASE_ADDRESS, default 18'd146944, gives the first SRAM word of packed RGB data.
REQ-003 Parameter NUM_PIXELS, default 76800, gives the pixel count per frame (320x240); it SHALL be even.
REQ-004 Parameter FIFO_DEPTH, default 4, gives the word-buffer depth.
REQ-005 Port Clock, input, 1 bit: rising-edge clock.
REQ-006 Port Reset, input, 1 bit: async active-high reset.
REQ-007 Port Enable, input, 1 bit: start pulse, sampled only in IDLE.
REQ-008 Port SRAM_address, output, 18 bits: read address.
REQ-009 Port SRAM_read_data, input, 16 bits: data for the address presented two cycles earlier.
REQ-010 Port SRAM_write_data, output, 16 bits: constant 0.
REQ-011 Port SRAM_we_n, output, 1 bit: constant 1 (read-only block).
REQ-012 Port pixel_valid, output, 1 bit: pixel_data holds a valid pixel.
REQ-013 Port pixel_data, output, 24 bits: {R[23:16], G[15:8], B[7:0]}.
REQ-014 Port pixel_ready, input, 1 bit: consumer accepts when pixel_valid and pixel_ready are both 1 on a rising edge.
REQ-015 Port Busy, output, 1 bit: 1 in any state other than IDLE.
REQ-016 Port Done, output, 1 bit: one-cycle pulse after the last pixel is accepted.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, DRAIN and DONE.
REQ-018 State transitions:
- IDLE -> FETCH on Enable=1, clearing all counters.
- FETCH -> DRAIN once 3*NUM_PIXELS/2 reads have been issued.
- DRAIN -> DONE once the last pixel is accepted.
- DONE -> IDLE unconditionally after one cycle.
REQ-019 Read issue in FETCH: SRAM_address = RGB_BASE_ADDRESS + word_count on any cycle where (FIFO occupancy + in-flight reads) < FIFO_DEPTH; word_count then increments.
REQ-020 In-flight tracking: each issued read SHALL be tracked by a 2-stage valid pipeline and its SRAM_read_data pushed into the FIFO exactly two cycles after issue.
REQ-021 Overflow: the FIFO SHALL never overflow; this is guaranteed by the credit rule in REQ-019, including when a push and a pop occur in the same cycle.
REQ-022 Word packing: words SHALL be packed per pixel pair as w0={R0,G0}, w1={B0,R1}, w2={G1,B1}.
REQ-023 Even phase: pixel_valid=1 when occupancy >= 2; pixel_data = {w0[15:8], w0[7:0], w1[15:8]}; on acceptance, pop 1 word and set phase to odd.
REQ-024 Odd phase: pixel_valid=1 when occupancy >= 2; pixel_data = {w1[7:0], w2[15:8], w2[7:0]}; on acceptance, pop 2 words and set phase to even.
REQ-025 Backpressure: while pixel_valid=1 and pixel_ready=0, pixel_data and pixel_valid SHALL hold stable, and reads continue only while credit remains.
REQ-026 Latency: first pixel_valid SHALL assert no later than 4 cycles after the Enable edge.
REQ-027 Pixel counter: SHALL count accepted pixels; the acceptance of pixel NUM_PIXELS-1 ends DRAIN.
REQ-028 Enable SHALL be ignored while Busy=1.
REQ-029 Throughput: with pixel_ready held at 1, the steady-state rate SHALL be 2 pixels per 3 cycles, and the frame SHALL complete within 3*NUM_PIXELS/2 + 8 cycles.
REQ-030 Address width: address arithmetic SHALL be 18-bit; RGB_BASE_ADDRESS + 3*NUM_PIXELS/2 - 1 SHALL not exceed 18'h3FFFF.

Reset
REQ-031 Reset=1 SHALL asynchronously force the following, regardless of current state, including mid-frame:
- state to IDLE
- SRAM_address to 0
- SRAM_we_n to 1
- SRAM_write_data to 0
- pixel_valid, pixel_data, Busy and Done to 0
- FIFO empty, in-flight pipeline cleared, phase even, all counters 0
REQ-032 Read data returning after reset SHALL be discarded.

Verification
REQ-033 Nominal: preload words 0x1122,0x3344,0x5566 at 146944, Enable pulse, pixel_ready=1 -> pixels 0x112233 then 0x445566; first address 146944; SRAM_we_n=1 throughout.
REQ-034 Full frame: NUM_PIXELS=76800, pixel_ready=1 -> exactly 76800 acceptances, last address 262143, one Done pulse, Busy falls with Done.
REQ-035 Backpressure: pixel_ready toggles 1,0,0,1 randomly -> pixel sequence identical to REQ-033 golden model, pixel_data stable while stalled, no FIFO overflow (occupancy <= 4).
REQ-036 Stall at start: pixel_ready=0 for 20 cycles after Enable -> exactly 4 reads issued, then address frozen at 146948 until ready rises.
REQ-037 Reset mid-frame: assert Reset after 100 pixels -> all outputs 0 and SRAM_we_n=1 immediately; a new Enable restarts at address 146944 with pixel 0.
REQ-038 Enable while busy: a second Enable pulse during FETCH -> no restart, pixel order unchanged.

Source files
------------

// File: rtl/rgb_pixel_streamer.sv
// rgb_pixel_streamer
//
// Streams one frame of packed RGB888 pixels out of a 16-bit SRAM. Every pixel pair lives in
// three consecutive words: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}. Reads are issued into a small
// word FIFO under a credit scheme; pixels are assembled from the two words at the FIFO head
// and handed out on a valid/ready interface.
//
// Ports
//   Clock           rising-edge clock
//   Reset           asynchronous active-high reset
//   Enable          start pulse, only looked at while idle
//   SRAM_address    read address (base + word index while fetching, else 0)
//   SRAM_read_data  data for the address presented two cycles earlier
//   SRAM_write_data tied to 0
//   SRAM_we_n       tied to 1 (read-only)
//   pixel_valid     pixel_data holds a pixel
//   pixel_data      {R, G, B}
//   pixel_ready     consumer accepts on a rising edge when pixel_valid is also 1
//   Busy            1 whenever not idle
//   Done            one-cycle pulse after the last pixel of the frame is accepted

module rgb_pixel_streamer #(
    parameter logic [17:0] RGB_BASE_ADDRESS = 18'd146944,
    parameter int unsigned NUM_PIXELS       = 76800,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    input  logic        pixel_ready,
    output logic        Busy,
    output logic        Done
);

    localparam int          Depth      = int'(FIFO_DEPTH);
    localparam int unsigned OccW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CreditW    = OccW + 2;
    localparam logic [17:0] TotalWords = 18'(3 * NUM_PIXELS / 2);
    localparam logic [17:0] LastPixel  = 18'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [17:0]       word_cnt_q, word_cnt_d;
    logic [17:0]       pix_cnt_q, pix_cnt_d;
    logic [17:0]       addr_q, addr_d;
    // [0]: read issued last cycle, [1]: its data is on SRAM_read_data this cycle
    logic [1:0]        rd_vld_q, rd_vld_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [15:0]       fifo_q [Depth];
    logic [15:0]       fifo_d [Depth];
    logic              phase_q, phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              push;
    logic              accept;
    logic              issue;
    logic [1:0]        pop_n;
    logic [CreditW-1:0] credit_used;
    logic [OccW-1:0]   wr_idx;

    // Pixel assembly: the head word and the one behind it always hold the current pixel.
    always_comb begin
        pixel_valid = (occ_q >= OccW'(2));
        pixel_data  = '0;
        if (pixel_valid) begin
            if (phase_q) begin
                pixel_data = {fifo_q[0][7:0], fifo_q[1]};
            end else begin
                pixel_data = {fifo_q[0], fifo_q[1][15:8]};
            end
        end
    end

    // Credit: words already buffered plus reads in flight, minus what leaves this cycle.
    // Counting the same-cycle pop keeps the loop at one read per cycle with a 4-deep FIFO,
    // and still cannot overflow because the pop happens on the same edge as the next push.
    always_comb begin
        accept      = pixel_valid & pixel_ready;
        pop_n       = accept ? (phase_q ? 2'd2 : 2'd1) : 2'd0;
        push        = rd_vld_q[1];
        credit_used = CreditW'(occ_q) + CreditW'(rd_vld_q[0]) + CreditW'(rd_vld_q[1])
                      - CreditW'(pop_n);
        issue       = (state_q == StFetch) && (credit_used < CreditW'(FIFO_DEPTH));
    end

    // Control path next state.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        phase_d    = phase_q;
        rd_vld_d   = {rd_vld_q[0], issue};

        if (accept) begin
            pix_cnt_d = pix_cnt_q + 18'd1;
            phase_d   = ~phase_q;
        end
        if (issue) begin
            word_cnt_d = word_cnt_q + 18'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (Enable) begin
                    state_d    = StFetch;
                    word_cnt_d = '0;
                    pix_cnt_d  = '0;
                    phase_d    = 1'b0;
                end
            end
            StFetch: begin
                if (issue && (word_cnt_q == TotalWords - 18'd1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (accept && (pix_cnt_q == LastPixel)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The address always shows the next word to read; it only counts as issued when
        // credit allows, so under backpressure it simply sits still.
        addr_d = (state_d == StFetch) ? (RGB_BASE_ADDRESS + word_cnt_d) : '0;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Word FIFO as a shift register: pops shift toward the head, pushes append at the tail.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (pop_n == 2'd1) begin
            for (int i = 0; i < Depth - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
            fifo_d[Depth - 1] = '0;
        end else if (pop_n == 2'd2) begin
            for (int i = 0; i < Depth - 2; i++) begin
                fifo_d[i] = fifo_q[i + 2];
            end
            fifo_d[Depth - 2] = '0;
            fifo_d[Depth - 1] = '0;
        end

        wr_idx = occ_q - OccW'(pop_n);
        for (int i = 0; i < Depth; i++) begin
            if (push && (wr_idx == OccW'(i))) begin
                fifo_d[i] = SRAM_read_data;
            end
        end

        occ_d = occ_q - OccW'(pop_n) + OccW'(push);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            addr_q     <= '0;
            rd_vld_q   <= '0;
            occ_q      <= '0;
            phase_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
            occ_q      <= occ_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fifo_q     <= fifo_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = '0;
    assign SRAM_we_n       = 1'b1;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Bench for rgb_pixel_streamer: SRAM model with two-cycle read latency, a word-array frame
// model that derives every expected pixel from the packing rule, and directed scenarios.
module tb_rgb_pixel_streamer;

    localparam logic [17:0] BASE   = 18'd146944;
    localparam int          NPIX   = 128;
    localparam int          NWORDS = 3 * NPIX / 2;
    localparam int          DEPTH  = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        Busy;
    logic        Done;

    logic [15:0] mem [NWORDS];
    logic [17:0] a1, a2;

    int          n_vec = 0;
    int          n_err = 0;
    int          acc_count = 0;
    int          done_pulses = 0;
    logic [17:0] last_addr = '0;
    logic [17:0] frame_last_addr = '0;

    rgb_pixel_streamer #(
        .RGB_BASE_ADDRESS(BASE),
        .NUM_PIXELS      (NPIX),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Enable         (Enable),
        .SRAM_address   (SRAM_address),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .pixel_ready    (pixel_ready),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clock = ~Clock;

    // Synchronous SRAM: data for the address seen in a cycle appears two cycles later.
    always @(posedge Clock) begin
        a1 <= SRAM_address;
        a2 <= a1;
    end

    always_comb begin
        SRAM_read_data = 16'hDEAD;
        if (a2 >= BASE && a2 < BASE + 18'(NWORDS)) begin
            SRAM_read_data = mem[int'(a2 - BASE)];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel k of the frame, straight from the pair packing w0={R0,G0} w1={B0,R1} w2={G1,B1}.
    function automatic logic [23:0] exp_pixel(input int k);
        int          j;
        logic [15:0] w0, w1, w2;
        j  = (k / 2) * 3;
        w0 = mem[j];
        w1 = mem[j + 1];
        w2 = mem[j + 2];
        if (k % 2 == 0) return {w0[15:8], w0[7:0], w1[15:8]};
        else            return {w1[7:0], w2[15:8], w2[7:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_enable();
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(SRAM_address), 32'd0);
        check({tag, "_we_n"},  32'(SRAM_we_n), 32'd1);
        check({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
        check({tag, "_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_data"},  32'(pixel_data), 32'd0);
        check({tag, "_busy"},  32'(Busy), 32'd0);
        check({tag, "_done"},  32'(Done), 32'd0);
    endtask

    // Wait for Done within the given budget, then confirm one pulse and Busy falling with it.
    task automatic finish_frame(input string tag, input int budget, input int pulses_before);
        int cyc;
        cyc = 0;
        while (!Done && cyc < budget) begin
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(Done), 32'd1);
        tick();
        check({tag, "_done_fall"}, 32'(Done), 32'd0);
        check({tag, "_busy_fall"}, 32'(Busy), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_pulses - pulses_before), 32'd1);
        check({tag, "_last_addr"}, 32'(frame_last_addr), 32'(BASE + 18'(NWORDS - 1)));
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            mem[i] = 16'((i * 4951) ^ 39619);
        end
        mem[0] = 16'h1122;
        mem[1] = 16'h3344;
        mem[2] = 16'h5566;

        fork
            begin : compare
                int          issued;
                int          consumed;
                logic        prev_stall;
                logic [23:0] prev_data;
                prev_stall = 1'b0;
                prev_data  = '0;
                forever begin
                    @(negedge Clock);
                    if (Reset) begin
                        acc_count  = 0;
                        prev_stall = 1'b0;
                    end else begin
                        check("we_n", 32'(SRAM_we_n), 32'd1);
                        check("wdata", 32'(SRAM_write_data), 32'd0);
                        if (prev_stall) begin
                            check("stall_valid", 32'(pixel_valid), 32'd1);
                            check("stall_data", 32'(pixel_data), 32'(prev_data));
                        end
                        if (SRAM_address != 18'd0) begin
                            issued   = int'(SRAM_address - BASE);
                            consumed = (acc_count / 2) * 3 + (acc_count % 2);
                            check("occupancy_le_depth", 32'(issued - consumed <= DEPTH), 32'd1);
                            last_addr = SRAM_address;
                        end
                        if (pixel_valid) begin
                            if (acc_count < NPIX) begin
                                check("pixel", 32'(pixel_data), 32'(exp_pixel(acc_count)));
                            end else begin
                                check("extra_pixel", 32'(pixel_valid), 32'd0);
                            end
                            if (pixel_ready) acc_count++;
                        end
                        prev_stall = pixel_valid && !pixel_ready;
                        prev_data  = pixel_data;
                        if (Done) begin
                            done_pulses++;
                            check("done_pixel_count", 32'(acc_count), 32'(NPIX));
                            check("done_busy", 32'(Busy), 32'd1);
                            frame_last_addr = last_addr;
                            acc_count = 0;
                        end
                    end
                end
            end
            begin : stimulus
                int          k;
                int          pulses;
                int          g;
                logic [3:0]  pat;
                logic [17:0] a_before;
                pat = 4'b1001;

                // Reset state
                #1 Reset = 1'b1;
                #1 check_reset_outputs("reset");
                tick();
                tick();
                Reset = 1'b0;
                tick();

                // Nominal start and a full frame with the consumer always ready
                pixel_ready = 1'b1;
                pulses = done_pulses;
                pulse_enable();
                check("nom_first_addr", 32'(SRAM_address), 32'(BASE));
                check("nom_busy", 32'(Busy), 32'd1);
                k = 0;
                while (!pixel_valid && k < 10) begin
                    tick();
                    k++;
                end
                check("nom_latency_le4", 32'(k <= 4), 32'd1);
                check("nom_pix0", 32'(pixel_data), 32'h0011_2233);
                tick();
                check("nom_pix1_valid", 32'(pixel_valid), 32'd1);
                check("nom_pix1", 32'(pixel_data), 32'h0044_5566);
                finish_frame("full", NWORDS + 8 - (k + 1), pulses);

                // Consumer stalled at start, then a 1,0,0,1 backpressure pattern
                pixel_ready = 1'b0;
                pulses = done_pulses;
                pulse_enable();
                repeat (19) tick();
                check("stall_addr_frozen", 32'(SRAM_address), 32'(BASE + 18'd4));
                check("stall_start_valid", 32'(pixel_valid), 32'd1);
                check("stall_start_pix0", 32'(pixel_data), 32'h0011_2233);
                g = 0;
                while (!Done && g < 20 * NWORDS) begin
                    pixel_ready = pat[g % 4] ^ ($urandom_range(0, 5) == 0);
                    tick();
                    g++;
                end
                pixel_ready = 1'b1;
                finish_frame("bp", 8, pulses);

                // Second Enable while busy must not restart the frame
                pulses = done_pulses;
                pulse_enable();
                repeat (8) tick();
                a_before = SRAM_address;
                pulse_enable();
                check("busy_enable_no_restart", 32'(SRAM_address > a_before), 32'd1);
                finish_frame("busy_en", NWORDS + 8, pulses);

                // Reset in the middle of a frame, then restart from scratch
                pulse_enable();
                g = 0;
                while (acc_count < 100 && g < 1000) begin
                    tick();
                    g++;
                end
                check("mid_reached_100", 32'(acc_count >= 100), 32'd1);
                #2 Reset = 1'b1;
                #1 check_reset_outputs("midreset");
                tick();
                tick();
                Reset = 1'b0;
                tick();
                pulses = done_pulses;
                pulse_enable();
                check("restart_first_addr", 32'(SRAM_address), 32'(BASE));
                k = 0;
                while (!pixel_valid && k < 10) begin
                    tick();
                    k++;
                end
                check("restart_pix0", 32'(pixel_data), 32'h0011_2233);
                finish_frame("restart", NWORDS + 8, pulses);
            end
        join_any

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
